// File: rtl/mux_n_1_arb.sv
// N:1 valid/ready multiplexer with a single registered output stage.
// Per-cycle grant comes from round-robin, fixed priority or an external index,
// chosen at elaboration time by MODE.
module mux_n_1_arb #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  ext_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch
);

  // Channel count at SEL_W+1 bits so the wrap compare never overflows.
  localparam logic [SEL_W:0]   NumChW  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N_CH - 1);

  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  logic [SEL_W:0]    scan;
  logic [W-1:0]      sel_data;
  logic              load_en;
  logic              xfer_in;

  // Pick at most one requesting channel according to MODE.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan      = '0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        scan = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
        if (scan >= NumChW) scan = scan - NumChW;
        if (!grant_any && in_valid[scan[SEL_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan[SEL_W-1:0];
        end
      end
    end else if (MODE == 1) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!grant_any && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Out-of-range index grants nothing; the range test short-circuits the lookup.
      if (({1'b0, ext_sel} < NumChW) && in_valid[ext_sel]) begin
        grant_any = 1'b1;
        grant_idx = ext_sel;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Route the granted channel's data; one-hot grant means at most one hit.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) sel_data = in_data[i*W +: W];
    end
  end

  // Accept only when the output stage is free or draining, and never in reset.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    in_ready = (load_en && rst_n) ? grant : '0;
    xfer_in  = grant_any && load_en && rst_n;
  end

  // Next state for the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      if (MODE == 0) rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
